// File: rtl/lock_pkg.sv
// Shared types and display glyphs for the combination lock.
// Imported by the sequencer and the seven-segment encoder.
package lock_pkg;

  typedef enum logic [2:0] {
    CLOSED    = 3'd0,
    TRIES     = 3'd1,
    OPEN      = 3'd2,
    DENIED    = 3'd3,
    COUNTDOWN = 3'd4
  } mode_t;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_O     = 7'b0111111;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_N     = 7'b1010100;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] g;
    g = SEG_BLANK;
    unique case (d)
      4'd0: g = SEG_0;
      4'd1: g = SEG_1;
      4'd2: g = SEG_2;
      4'd3: g = SEG_3;
      4'd4: g = SEG_4;
      4'd5: g = SEG_5;
      4'd6: g = SEG_6;
      4'd7: g = SEG_7;
      4'd8: g = SEG_8;
      4'd9: g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/lock_sequencer_sec_tick.sv
// One-second tick generator: free-running modulo-CLK_HZ counter.
// clr restarts the second so lockout phases start on a boundary.
module sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Not gated by clr: the FSM raises clr on the same tick it consumes
  assign tick = (cnt == LAST);

endmodule

// File: rtl/lock_sequencer.sv
// Combination lock sequencer: submit sync/edge, attempt tracking,
// DENIED hold and lockout countdown driving the display fields.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int         CLK_HZ        = 50_000_000,
  parameter int         ATTEMPTS      = 3,
  parameter int         DENY_SEC      = 5,
  parameter int         COUNTDOWN_SEC = 55,
  parameter logic [7:0] PASSCODE      = 8'h49
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       submit,
  input  logic [7:0] passcode_attempt,
  output mode_t      mode,
  output logic [1:0] tries_left,
  output logic [5:0] count_sec,
  output logic       unlocked,
  output logic       bad_attempt
);

  localparam logic [1:0] ATT = 2'(ATTEMPTS);
  localparam logic [5:0] CD  = 6'(COUNTDOWN_SEC);
  localparam int DW = (DENY_SEC > 1) ? $clog2(DENY_SEC) : 1;
  localparam logic [DW-1:0] DENY_LAST = DW'(DENY_SEC - 1);

  logic          sync1, sync2, sync3;
  logic          evt;
  logic          tick;
  logic          clr;
  logic [DW-1:0] deny_cnt, deny_d;
  mode_t         mode_d;
  logic [1:0]    tries_d;
  logic [5:0]    count_d;
  logic          bad_d;

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= submit;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign evt = sync2 & ~sync3;

  always_comb begin
    mode_d  = mode;
    tries_d = tries_left;
    count_d = count_sec;
    deny_d  = deny_cnt;
    bad_d   = 1'b0;
    clr     = 1'b0;
    unique case (mode)
      CLOSED: begin
        if (en) mode_d = TRIES;
      end
      TRIES: begin
        // A submit landing with en falling is judged before closing
        if (evt) begin
          if (passcode_attempt == PASSCODE) begin
            tries_d = ATT;
            mode_d  = en ? OPEN : CLOSED;
          end else begin
            bad_d = 1'b1;
            if (tries_left <= 2'd1) begin
              tries_d = 2'd0;
              mode_d  = DENIED;
              deny_d  = '0;
              clr     = 1'b1;
            end else begin
              tries_d = tries_left - 2'd1;
              if (!en) mode_d = CLOSED;
            end
          end
        end else if (!en) begin
          mode_d = CLOSED;
        end
      end
      OPEN: begin
        if (!en) mode_d = CLOSED;
      end
      DENIED: begin
        if (tick) begin
          if (deny_cnt == DENY_LAST) begin
            mode_d  = COUNTDOWN;
            count_d = CD;
            clr     = 1'b1;
          end else begin
            deny_d = deny_cnt + 1'b1;
          end
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (count_sec == 6'd0) begin
            tries_d = ATT;
            mode_d  = en ? TRIES : CLOSED;
          end else begin
            count_d = count_sec - 6'd1;
          end
        end
      end
      default: begin
        mode_d = CLOSED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= CLOSED;
      tries_left  <= ATT;
      count_sec   <= 6'd0;
      deny_cnt    <= '0;
      unlocked    <= 1'b0;
      bad_attempt <= 1'b0;
    end else begin
      mode        <= mode_d;
      tries_left  <= tries_d;
      count_sec   <= count_d;
      deny_cnt    <= deny_d;
      unlocked    <= (mode_d == OPEN);
      bad_attempt <= bad_d;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a 10-cycle second
// and a 3-second countdown.
module tb_lock_sequencer;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       submit;
  logic [7:0] passcode_attempt;
  mode_t      mode;
  logic [1:0] tries_left;
  logic [5:0] count_sec;
  logic       unlocked;
  logic       bad_attempt;

  int checks = 0;
  int errors = 0;
  int bad_cnt = 0;
  int b0;
  int n;
  bit unl_seen = 1'b0;

  lock_sequencer #(
    .CLK_HZ       (10),
    .ATTEMPTS     (3),
    .DENY_SEC     (5),
    .COUNTDOWN_SEC(3),
    .PASSCODE     (8'h49)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .submit          (submit),
    .passcode_attempt(passcode_attempt),
    .mode            (mode),
    .tries_left      (tries_left),
    .count_sec       (count_sec),
    .unlocked        (unlocked),
    .bad_attempt     (bad_attempt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bad_attempt === 1'b1) bad_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the first sample after the FSM consumed the event
  task automatic press(input logic [7:0] code, input bit drop_en);
    passcode_attempt = code;
    @(negedge clk) submit = 1'b1;
    @(negedge clk);
    @(negedge clk) if (drop_en) en = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_sub();
    submit = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Counts consecutive samples with unchanged {mode,count_sec}
  task automatic hold(input bit byp, input int lim, output int len);
    logic [8:0] snap;
    snap = {mode, count_sec};
    len = 1;
    while (len < 600) begin
      if (byp) begin
        passcode_attempt = 8'h49;
        if (len < lim) begin
          en     = ~len[1];
          submit = len[2];
        end else begin
          en     = 1'b1;
          submit = 1'b0;
        end
      end
      @(negedge clk);
      if (unlocked) unl_seen = 1'b1;
      if ({mode, count_sec} !== snap) break;
      len++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    submit = 1'b0;
    passcode_attempt = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mode", 32'(mode), 32'(CLOSED));
    chk("rst_tries", 32'(tries_left), 32'd3);
    chk("rst_count", 32'(count_sec), 32'd0);
    chk("rst_unl", 32'(unlocked), 32'd0);
    chk("rst_bad", 32'(bad_attempt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("closed_idle", 32'(mode), 32'(CLOSED));
    en = 1'b1;
    @(negedge clk);
    chk("en_tries", 32'(mode), 32'(TRIES));

    press(8'h49, 1'b0);
    chk("ok_mode", 32'(mode), 32'(OPEN));
    chk("ok_unl", 32'(unlocked), 32'd1);
    chk("ok_tries", 32'(tries_left), 32'd3);
    release_sub();
    chk("ok_nobad", 32'(bad_cnt), 32'd0);
    en = 1'b0;
    @(negedge clk);
    chk("open_close", 32'(mode), 32'(CLOSED));
    chk("close_unl", 32'(unlocked), 32'd0);
    en = 1'b1;
    @(negedge clk);

    press(8'h00, 1'b0);
    chk("w1_mode", 32'(mode), 32'(TRIES));
    chk("w1_tries", 32'(tries_left), 32'd2);
    chk("w1_bad", 32'(bad_attempt), 32'd1);
    @(negedge clk);
    chk("w1_badpulse", 32'(bad_attempt), 32'd0);
    release_sub();
    press(8'h01, 1'b0);
    chk("w2_tries", 32'(tries_left), 32'd1);
    release_sub();
    press(8'h49, 1'b0);
    chk("w3_open", 32'(mode), 32'(OPEN));
    chk("w3_tries", 32'(tries_left), 32'd3);
    release_sub();
    chk("w3_badcnt", 32'(bad_cnt), 32'd2);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);

    press(8'h00, 1'b0);
    release_sub();
    press(8'h01, 1'b0);
    release_sub();
    press(8'h02, 1'b0);
    chk("lk_mode", 32'(mode), 32'(DENIED));
    chk("lk_tries", 32'(tries_left), 32'd0);
    chk("lk_bad", 32'(bad_attempt), 32'd1);
    hold(1'b1, 44, n);
    chk("deny_len", 32'(n), 32'd50);
    chk("cd_mode", 32'(mode), 32'(COUNTDOWN));
    for (int v = 3; v >= 0; v--) begin
      chk("cd_val", 32'(count_sec), 32'(v));
      hold(1'b1, 6, n);
      chk("cd_len", 32'(n), 32'd10);
    end
    chk("lk_end_mode", 32'(mode), 32'(TRIES));
    chk("lk_end_tries", 32'(tries_left), 32'd3);
    chk("lk_unl", 32'(unl_seen), 32'd0);

    press(8'h00, 1'b0);
    release_sub();
    chk("ck_tries", 32'(tries_left), 32'd2);
    en = 1'b0;
    @(negedge clk);
    chk("ck_closed", 32'(mode), 32'(CLOSED));
    en = 1'b1;
    @(negedge clk);
    chk("ck_reopen", 32'(mode), 32'(TRIES));
    chk("ck_kept", 32'(tries_left), 32'd2);
    b0 = bad_cnt;
    press(8'h03, 1'b0);
    repeat (100) @(negedge clk);
    chk("hold_tries", 32'(tries_left), 32'd1);
    chk("hold_bad", 32'(bad_cnt - b0), 32'd1);
    release_sub();

    press(8'h49, 1'b1);
    chk("sim_ok_mode", 32'(mode), 32'(CLOSED));
    chk("sim_ok_tries", 32'(tries_left), 32'd3);
    chk("sim_ok_unl", 32'(unlocked), 32'd0);
    release_sub();
    en = 1'b1;
    @(negedge clk);
    press(8'h00, 1'b0);
    release_sub();
    press(8'h01, 1'b0);
    release_sub();
    press(8'h02, 1'b1);
    chk("sim_bad_mode", 32'(mode), 32'(DENIED));
    chk("sim_bad_tries", 32'(tries_left), 32'd0);
    hold(1'b0, 0, n);
    chk("deny_len2", 32'(n), 32'd50);
    submit = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_cd_mode", 32'(mode), 32'(COUNTDOWN));
    chk("mid_cd_val", 32'(count_sec), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'(CLOSED));
    chk("arst_tries", 32'(tries_left), 32'd3);
    chk("arst_count", 32'(count_sec), 32'd0);
    chk("arst_unl", 32'(unlocked), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", 32'(mode), 32'(CLOSED));
    en = 1'b1;
    @(negedge clk);
    chk("post_tries_mode", 32'(mode), 32'(TRIES));
    chk("post_tries", 32'(tries_left), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
